uart_tx_frame: RTL and testbench

- Frame sequencer for the UART transmit path. Sits directly upstream of the serial line.
- Accepts one data word over a valid/ready handshake, then serialises it: start bit (0), DataBits data bits LSB first, StopBits stop bits (1).
- Owns its bit timing with one baud counter. Pulses done when the last stop bit completes, so a byte source or FIFO can pace the next word.

---
 rtl/uart_tx_frame.sv | 111 +++++++++++
 tb/tb_uart_tx_frame.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit frame sequencer: start bit, LSB-first data, stop bits.
module uart_tx_frame #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int DataBits       = 8,
  parameter int StopBits       = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DataBits-1:0] data,
  input  logic                valid,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                tx
);

  localparam int BitCycles  = ClockFrequency / BaudRate;
  localparam int StopCycles = BitCycles * StopBits;
  localparam int CntWidth   = (StopCycles > 2) ? $clog2(StopCycles) : 1;
  localparam int IdxWidth   = $clog2(DataBits);

  localparam logic [CntWidth-1:0] BitLast  = CntWidth'(BitCycles - 1);
  localparam logic [CntWidth-1:0] StopLast = CntWidth'(StopCycles - 1);
  localparam logic [IdxWidth-1:0] IdxLast  = IdxWidth'(DataBits - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state;
  logic [CntWidth-1:0] cnt;
  logic [IdxWidth-1:0] bit_idx;
  logic [DataBits-1:0] shreg;

  // The stop phase runs as one long count so the counter only restarts at frame end.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            shreg   <= data;
            tx      <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (cnt == BitLast) begin
            cnt   <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (bit_idx == IdxLast) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == StopLast) begin
            cnt   <= '0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed self-checking bench for uart_tx_frame.
module tb_uart_tx_frame;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] da = 8'h00;
  logic       va = 1'b0;
  logic       ra, ba, dna, txa;
  logic [6:0] db = 7'h00;
  logic       vb = 1'b0;
  logic       rb, bb, dnb, txb;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(
    .ClockFrequency(1000), .BaudRate(100), .DataBits(8), .StopBits(1)
  ) dut_a (
    .clock(clock), .reset(reset), .data(da), .valid(va),
    .ready(ra), .busy(ba), .done(dna), .tx(txa)
  );

  uart_tx_frame #(
    .ClockFrequency(1000), .BaudRate(100), .DataBits(7), .StopBits(2)
  ) dut_b (
    .clock(clock), .reset(reset), .data(db), .valid(vb),
    .ready(rb), .busy(bb), .done(dnb), .tx(txb)
  );

  typedef struct packed {
    logic [9:0] bits;
    int         glitches;
    int         done_at;
    int         done_cnt;
    int         busy_cnt;
    logic       rdy_end;
    logic       tx_first;
    logic       tx_last;
  } cap_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples 101 negedges following an accept edge: k=0..99 is the frame, k=100 the done cycle.
  task automatic capture(input bit sel, input bit noise, output cap_t c);
    logic t;
    logic p;
    c = '0;
    c.done_at = -1;
    p = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      @(negedge clock);
      t = sel ? txb : txa;
      if (k == 0) c.tx_first = t;
      if (k == 100) begin
        c.tx_last = t;
        c.rdy_end = sel ? rb : ra;
      end
      if (k < 100 && (k % 10) == 5) c.bits[k / 10] = t;
      if (k > 0 && k < 100 && (k % 10) != 0 && t !== p) c.glitches = c.glitches + 1;
      p = t;
      if ((sel ? dnb : dna) === 1'b1) begin
        c.done_cnt = c.done_cnt + 1;
        if (c.done_at < 0) c.done_at = k;
      end
      if (k < 100 && (sel ? rb : ra) === 1'b0 && (sel ? bb : ba) === 1'b1)
        c.busy_cnt = c.busy_cnt + 1;
      if (noise) begin
        va = (k < 98) ? k[0] : 1'b0;
        da = 8'hFF;
      end
    end
  endtask

  task automatic chk_frame(input string n, input cap_t c, input logic [9:0] eb);
    chk({n, "_bits"}, 32'(c.bits), 32'(eb));
    chk({n, "_glitches"}, c.glitches, 0);
    chk({n, "_done_at"}, c.done_at, 100);
    chk({n, "_done_cnt"}, c.done_cnt, 1);
    chk({n, "_busy_cnt"}, c.busy_cnt, 100);
    chk({n, "_ready_end"}, 32'(c.rdy_end), 1);
  endtask

  initial begin
    cap_t c;
    int   bad;

    // Asynchronous reset between clock edges
    #12 reset = 1'b0;
    #1;
    chk("rst_tx", 32'(txa), 1);
    chk("rst_ready", 32'(ra), 1);
    chk("rst_busy", 32'(ba), 0);
    chk("rst_done", 32'(dna), 0);
    chk("rst_b_tx", 32'(txb), 1);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (txa !== 1'b1 || ra !== 1'b1 || ba !== 1'b0 || dna !== 1'b0 || txb !== 1'b1 || rb !== 1'b1)
        bad++;
    end
    chk("idle_50", bad, 0);

    // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,1
    da = 8'hA5; va = 1'b1;
    @(posedge clock); #1 va = 1'b0; da = 8'h00;
    capture(1'b0, 1'b0, c);
    chk_frame("a5", c, 10'b1101001010);

    // Back-to-back 0x00 then 0xFF with valid held
    repeat (3) @(negedge clock);
    da = 8'h00; va = 1'b1;
    @(posedge clock); #1 da = 8'hFF;
    capture(1'b0, 1'b0, c);
    chk_frame("b2b_first", c, 10'b1000000000);
    chk("b2b_tx_done_cycle", 32'(c.tx_last), 1);
    @(posedge clock); #1 va = 1'b0;
    capture(1'b0, 1'b0, c);
    chk_frame("b2b_second", c, 10'b1111111110);
    chk("b2b_start_after_gap", 32'(c.tx_first), 0);
    repeat (5) @(negedge clock);
    chk("b2b_no_third", 32'(ra), 1);

    // 0x3C with valid toggling and data=0xFF while busy
    da = 8'h3C; va = 1'b1;
    @(posedge clock); #1 va = 1'b0; da = 8'hFF;
    capture(1'b0, 1'b1, c);
    chk_frame("busy_3c", c, 10'b1001111000);
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (txa !== 1'b1 || ra !== 1'b1 || dna !== 1'b0) bad++;
    end
    chk("busy_no_extra_frame", bad, 0);

    // Reset 45 cycles into a 0x55 frame (tx low in data bit 3)
    da = 8'h55; va = 1'b1;
    @(posedge clock); #1 va = 1'b0;
    repeat (45) @(negedge clock);
    chk("mid_pre_tx", 32'(txa), 0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(txa), 1);
    chk("mid_rst_ready", 32'(ra), 1);
    chk("mid_rst_busy", 32'(ba), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (dna !== 1'b0 || txa !== 1'b1) bad++;
    end
    #1 reset = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (dna !== 1'b0 || txa !== 1'b1 || ra !== 1'b1) bad++;
    end
    chk("mid_no_done", bad, 0);

    da = 8'h81; va = 1'b1;
    @(posedge clock); #1 va = 1'b0;
    capture(1'b0, 1'b0, c);
    chk_frame("after_rst_81", c, 10'b1100000010);

    // 7 data bits, 2 stop bits: 0x41
    db = 7'h41; vb = 1'b1;
    @(posedge clock); #1 vb = 1'b0;
    capture(1'b1, 1'b0, c);
    chk_frame("b_7n2_41", c, 10'b1110000010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
